// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between pipeline and word-addressed data memory
module load_store_unit #(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_STORE,
    S_RESP
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        err_q;
  logic [31:0] word_q;   // store data on acceptance, merged write word after RMW_RD
  logic [31:0] rdata_q;

  logic accept;
  logic req_misaligned;
  logic req_out_of_range;
  logic req_err;

  // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  ofs,
                                              input logic [1:0]  size,
                                              input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{ofs, 3'b000} +: 8];
    h = word[{ofs[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = zext ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = zext ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the old memory word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [1:0]  ofs,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = old_word;
    case (size)
      2'b00:   r[{ofs, 3'b000} +: 8] = data[7:0];
      2'b01:   r[{ofs[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

  assign accept           = req_valid && (state == S_IDLE);
  assign req_out_of_range = (req_addr >> ADDR_BITS) != 32'd0;
  assign req_misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                            ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err          = (req_size == 2'b11) || req_misaligned || req_out_of_range;

  // State register; reset drops straight back to IDLE regardless of clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and all outputs decoded from the current state.
  always_comb begin
    next_state     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_error     = 1'b0;
    resp_rdata     = 32'd0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = {addr_q[31:2], 2'b00};
    mem_write_data = 32'd0;
    case (state)
      S_IDLE: begin
        req_ready   = 1'b1;
        mem_address = 32'd0;
        if (req_valid) begin
          if (req_err) begin
            next_state = S_RESP;
          end else if (!req_write) begin
            next_state = S_LOAD;
          end else if (req_size == 2'b10) begin
            next_state = S_STORE;
          end else begin
            next_state = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        mem_read   = 1'b1;
        next_state = S_RESP;
      end
      S_RMW_RD: begin
        mem_read   = 1'b1;
        next_state = S_STORE;
      end
      S_STORE: begin
        mem_write      = 1'b1;
        mem_write_data = word_q;
        next_state     = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = rdata_q;
        next_state = S_IDLE;
      end
      default: begin
        mem_address = 32'd0;
        next_state  = S_IDLE;
      end
    endcase
  end

  // Request capture at acceptance, load result and read-modify-write merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= 32'd0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        err_q      <= req_err;
        word_q     <= req_wdata;
        rdata_q    <= 32'd0;
      end
      if (state == S_LOAD) begin
        rdata_q <= load_extend(mem_read_data, addr_q[1:0], size_q, unsigned_q);
      end
      if (state == S_RMW_RD) begin
        word_q <= store_merge(mem_read_data, word_q, addr_q[1:0], size_q);
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_BITS, default 14, byte-address width of the attached data memory (16 KB); request address bits [31:ADDR_BITS] nonzero are out of range.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 req_valid  input  1  pipeline request present.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal and flagged as error.
REQ-008 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  output  1  misaligned, out-of-range or illegal-size request; qualified by resp_valid.
REQ-014 mem_read  output  1  read strobe to word-addressed data memory.
REQ-015 mem_write  output  1  write strobe; memory writes on the rising edge while high.
REQ-016 mem_address  output  32  word-aligned byte address (bits [1:0] always 0).
REQ-017 mem_write_data  output  32  full word to write.
REQ-018 mem_read_data  input  32  combinational read data, valid the same cycle mem_read is high.

Function
REQ-019 A request is accepted on a rising edge where req_valid and req_ready are both 1; all req_* fields are latched at that edge and ignored afterwards.
REQ-020 States: IDLE, LOAD, RMW_RD, STORE, RESP; no other states reachable.
REQ-021 Error check at acceptance: halfword with addr[0]=1, word with addr[1:0]!=0, size 11, or out-of-range address -> IDLE to RESP with resp_error=1 and no memory strobe ever asserted.
REQ-022 Load: IDLE -> LOAD (mem_read=1; lane selected and extended data registered at the edge ending LOAD) -> RESP.
REQ-023 Word store: IDLE -> STORE (mem_write=1, mem_write_data=req_wdata) -> RESP.
REQ-024 Byte/halfword store: IDLE -> RMW_RD (mem_read=1, word registered) -> STORE (mem_write=1, registered word with only the addressed lane(s) replaced) -> RESP.
REQ-025 Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0], 3 selects [31:24]; halfword addr[1]=0 selects [15:0], 1 selects [31:16].
REQ-026 Latency from the acceptance edge (cycle N): resp_valid high in cycle N+1 on error, N+2 for load and word store, N+3 for sub-word store.
REQ-027 RESP lasts exactly one cycle and always returns to IDLE; back-to-back requests are therefore separated by at least one IDLE cycle.
REQ-028 mem_read and mem_write are never high together and are 0 in IDLE and RESP.
REQ-029 mem_address = latched address with bits [1:0] forced to 0 in all non-IDLE states; 0 in IDLE.
REQ-030 req_valid deasserting after acceptance has no effect on an operation in flight.

Reset
REQ-031 rst_n low forces IDLE immediately, independent of clk: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
REQ-032 Reset asserted mid-operation abandons it with no resp_valid; a STORE aborted before its rising edge performs no write.
REQ-033 First request after rst_n rises is accepted at the first rising edge where req_valid=1.

Verification
REQ-034 Memory word 0x100 = 0x8899AABB; load byte signed at 0x101 -> mem_read in N+1, resp_rdata=0xFFFFFFAA in N+2; unsigned -> 0x000000AA.
REQ-035 Store halfword 0x1234 at 0x102 over 0x8899AABB -> mem_read in N+1, mem_write with 0x1234AABB in N+2, resp_valid in N+3, resp_error=0.
REQ-036 Store word 0xDEADBEEF at 0x200 -> mem_write in N+1 only, mem_address=0x200, then load word at 0x200 returns 0xDEADBEEF.
REQ-037 Load word at 0x203, halfword at 0x001, size 11, and address 0x4000 -> each gives resp_valid with resp_error=1 in N+1, mem_read/mem_write never high.
REQ-038 Assert rst_n low during STORE state of a byte store -> outputs at reset values immediately, memory word unchanged, no resp_valid.
REQ-039 req_valid held high continuously for three loads -> acceptances every 3 cycles, req_ready low between, each resp_valid a single-cycle pulse.
